demux_router_reg: RTL and testbench
===================================

Name: demux_router_reg

Overview:
- Registered, parametrised successor to the 8-bit 1-to-3 bus demultiplexer used on the datapath.
- Routes one input word to one of CHANNELS output channels selected by S. Select value 0 means no destination: the word is consumed and discarded.
- Each channel has a one-entry output register with a valid/ready handshake, so a destination can stall without losing data.
- A saturating counter records discarded words, for debug visibility.

Parameters:
- WIDTH, 8, data width of input and of each output channel.
- CHANNELS, 3, number of output channels (1..15).
- SEL_W, 2, select width. Must satisfy 2^SEL_W > CHANNELS.
- HOLD, 1. 1: a channel's Q keeps its last data after consumption. 0: Q reads 0 whenever QV is 0.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- I  input  WIDTH  input data word.
- S  input  SEL_W  destination select. 0 = discard; k (1..CHANNELS) = channel k.
- IV  input  1  input valid.
- IR  output  1  input ready.
- Q  output  CHANNELS*WIDTH  flattened channel data. Channel k occupies bits [k*WIDTH-1 : (k-1)*WIDTH].
- QV  output  CHANNELS  per-channel valid; bit k-1 is channel k.
- QR  input  CHANNELS  per-channel ready from the consumer.
- DROPS  output  8  saturating count of discarded input words.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset (RST high at a clock edge): QV = 0, every channel's Q = 0, DROPS = 0. RST overrides any transfer or drain in the same cycle. IR is combinational and still follows the rule below during reset, but no state changes.
- Discard selects: S = 0 and S > CHANNELS (out of range) are both discard selects.
- IR (combinational):
  - Discard select: IR = 1.
  - S = k: IR = !QV[k-1] || QR[k-1]. IR therefore depends combinationally on QR; consumers must not make QR depend on IR.
- Input transfer: occurs when IV && IR at the clock edge. I and S are sampled only then.
  - S = k: the channel k data register loads I and QV[k-1] is 1 after that edge. Latency input to QV is exactly 1 cycle.
  - Discard select: no channel changes. DROPS increments by 1, saturating at 255 (stays 255).
- Channel drain: when QV[k-1] && QR[k-1] at an edge, QV[k-1] clears, unless the same edge also loads channel k.
  - Simultaneous drain and load: QV stays 1 and the data becomes the new word. Back-to-back throughput is one word per cycle per channel.
- Stall: when QV[k-1] = 1 and QR[k-1] = 0, channel k holds its data and QV. An input selecting k sees IR = 0, and the source must hold I and S stable.
- Independence: channels drain independently. Loading one channel never alters another channel's data or QV.
- Q visibility:
  - HOLD = 1: channel data is visible on Q regardless of QV.
  - HOLD = 0: channel Q is forced to 0 while its QV = 0.
- IV low: no transfer, no DROPS change. Drains still proceed.
- Unknown or X on S while IV = 0 must not corrupt state.

Test Plan:
- Reset then S=2, I=8'hA5, IV=1 for one cycle, QR=3'b111 -> next cycle QV=3'b010, channel 2 Q=8'hA5; following cycle QV=3'b000. With HOLD=1, Q2 stays 8'hA5.
- QR[0]=0, send 8'h11 then 8'h22 to S=1 -> first accepted; IR=0 on the second word until QR[0]=1. Then 8'h22 loads in the same cycle 8'h11 drains, and QV[0] stays 1.
- Five words with S=0 and two with S=3 (CHANNELS=3, SEL_W=2; S=3 is a valid channel) -> DROPS=5, channel 3 receives both words in order. Repeat with CHANNELS=2: S=3 counts as a drop.
- 300 consecutive S=0 transfers -> DROPS saturates at 255 with no wrap to 0.
- HOLD=0 build: load 8'h3C to channel 1 and drain it -> Q1 reads 8'h3C while QV[0]=1, then reads 8'h00.
- Assert RST in the same cycle as an accepted transfer to channel 2 with QV[1] previously 1 -> QV=0, Q=0 and DROPS=0 after the edge.

Source files
------------

// File: rtl/demux_router_reg.sv
// Registered 1-to-CHANNELS demultiplexer with a one-entry valid/ready register per channel.
// A select of 0 or beyond CHANNELS discards the word and bumps a saturating drop counter.
module demux_router_reg #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 3,
  parameter int SEL_W    = 2,
  parameter int HOLD     = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [WIDTH-1:0]          I,
  input  logic [SEL_W-1:0]          S,
  input  logic                      IV,
  output logic                      IR,
  output logic [CHANNELS*WIDTH-1:0] Q,
  output logic [CHANNELS-1:0]       QV,
  input  logic [CHANNELS-1:0]       QR,
  output logic [7:0]                DROPS
);

  logic [WIDTH-1:0]    data_q [CHANNELS];
  logic [WIDTH-1:0]    data_d [CHANNELS];
  logic [CHANNELS-1:0] qv_q, qv_d;
  logic [7:0]          drops_q, drops_d;
  logic [CHANNELS-1:0] hit;
  logic                discard;
  logic                fire;

  // Select decode: an out-of-range S matches no channel and is treated like S = 0.
  always_comb begin
    hit = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      hit[k] = (S == SEL_W'(k + 1));
    end
    discard = ~|hit;
    IR      = discard | (|(hit & (~qv_q | QR)));
    fire    = IV && IR;
  end

  // NOTE: every output of a combinational block gets a default before any branch, so no latch is inferred.
  always_comb begin
    qv_d    = qv_q;
    drops_d = drops_q;
    for (int k = 0; k < CHANNELS; k++) begin
      data_d[k] = data_q[k];
      if (fire && hit[k]) begin
        data_d[k] = I;
        qv_d[k]   = 1'b1;
      end else if (qv_q[k] && QR[k]) begin
        qv_d[k]   = 1'b0;
      end
    end
    if (fire && discard && (drops_q != 8'hFF)) begin
      drops_d = drops_q + 8'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      qv_q    <= '0;
      drops_q <= '0;
      // NOTE: the data registers are cleared too, because Q must read 0 after reset even with HOLD = 1.
      for (int k = 0; k < CHANNELS; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      qv_q    <= qv_d;
      drops_q <= drops_d;
      for (int k = 0; k < CHANNELS; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_q
    assign Q[k*WIDTH +: WIDTH] = ((HOLD != 0) || qv_q[k]) ? data_q[k] : '0;
  end

  assign QV    = qv_q;
  assign DROPS = drops_q;

endmodule

// File: tb/tb_demux_router_reg.sv
// Bench for demux_router_reg: three builds (3 channels/HOLD=1, 2 channels, HOLD=0) share one
// input stream; each is tracked by a word-level reference model and checked every cycle.
module tb_demux_router_reg;

  typedef struct packed {
    logic [2:0][7:0] data;
    logic [2:0]      qv;
    logic [7:0]      drops;
  } mdl_t;

  logic        clk;
  logic        rst;
  logic        iv;
  logic [7:0]  i_w;
  logic [1:0]  s;
  logic [2:0]  qr;
  logic        ir_a, ir_b, ir_c;
  logic [23:0] q_a, q_c;
  logic [15:0] q_b;
  logic [2:0]  qv_a, qv_c;
  logic [1:0]  qv_b;
  logic [7:0]  drops_a, drops_b, drops_c;

  int   errors = 0;
  int   checks = 0;
  mdl_t ma, mb, mc;

  demux_router_reg #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .HOLD(1)) u_a (
    .CLK(clk), .RST(rst), .I(i_w), .S(s), .IV(iv), .IR(ir_a),
    .Q(q_a), .QV(qv_a), .QR(qr), .DROPS(drops_a));

  demux_router_reg #(.WIDTH(8), .CHANNELS(2), .SEL_W(2), .HOLD(1)) u_b (
    .CLK(clk), .RST(rst), .I(i_w), .S(s), .IV(iv), .IR(ir_b),
    .Q(q_b), .QV(qv_b), .QR(qr[1:0]), .DROPS(drops_b));

  demux_router_reg #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .HOLD(0)) u_c (
    .CLK(clk), .RST(rst), .I(i_w), .S(s), .IV(iv), .IR(ir_c),
    .Q(q_c), .QV(qv_c), .QR(qr), .DROPS(drops_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ir(mdl_t m, int chans, int sel, logic [2:0] rdy);
    if (sel < 1 || sel > chans) return 1'b1;
    return !m.qv[sel-1] || rdy[sel-1];
  endfunction

  function automatic mdl_t step(mdl_t m, int chans, bit r, bit v, int sel,
                                logic [7:0] d, logic [2:0] rdy);
    mdl_t n;
    n = m;
    if (r) return '0;
    for (int c = 0; c < chans; c++) begin
      if (m.qv[c] && rdy[c]) n.qv[c] = 1'b0;
    end
    if (v && model_ir(m, chans, sel, rdy)) begin
      if (sel < 1 || sel > chans) begin
        n.drops = (m.drops == 8'd255) ? m.drops : m.drops + 8'd1;
      end else begin
        n.data[sel-1] = d;
        n.qv[sel-1]   = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic logic [23:0] exp_q(mdl_t m, int chans, bit hold);
    logic [23:0] r;
    r = '0;
    for (int c = 0; c < chans; c++) begin
      if (hold || m.qv[c]) r[c*8 +: 8] = m.data[c];
    end
    return r;
  endfunction

  // One clock: check IR against the models, take the edge, advance the models, check outputs.
  task automatic tick();
    int sel;
    #1;
    sel = int'(s);
    if (!rst && !$isunknown(s)) begin
      check("a.IR", 32'(ir_a), 32'(model_ir(ma, 3, sel, qr)));
      check("b.IR", 32'(ir_b), 32'(model_ir(mb, 2, sel, qr)));
      check("c.IR", 32'(ir_c), 32'(model_ir(mc, 3, sel, qr)));
    end
    @(posedge clk);
    ma = step(ma, 3, rst, iv, sel, i_w, qr);
    mb = step(mb, 2, rst, iv, sel, i_w, qr);
    mc = step(mc, 3, rst, iv, sel, i_w, qr);
    #1;
    check("a.Q", 32'(q_a), 32'(exp_q(ma, 3, 1'b1)));
    check("a.QV", 32'(qv_a), 32'(ma.qv));
    check("a.DROPS", 32'(drops_a), 32'(ma.drops));
    check("b.Q", 32'({8'h00, q_b}), 32'(exp_q(mb, 2, 1'b1)));
    check("b.QV", 32'(qv_b), 32'(mb.qv[1:0]));
    check("b.DROPS", 32'(drops_b), 32'(mb.drops));
    check("c.Q", 32'(q_c), 32'(exp_q(mc, 3, 1'b0)));
    check("c.QV", 32'(qv_c), 32'(mc.qv));
    check("c.DROPS", 32'(drops_c), 32'(mc.drops));
  endtask

  task automatic drive(input bit r, input bit v, input logic [1:0] sel,
                       input logic [7:0] d, input logic [2:0] rdy);
    rst = r; iv = v; s = sel; i_w = d; qr = rdy;
  endtask

  initial begin
    drive(1'b1, 1'b0, 2'd0, 8'h00, 3'b000);
    repeat (2) @(posedge clk);
    ma = '0; mb = '0; mc = '0;
    #1;
    check("reset.QV", 32'(qv_a), 32'h0);
    check("reset.Q", 32'(q_a), 32'h0);
    check("reset.DROPS", 32'(drops_a), 32'h0);
    tick();

    // Single word to channel 2, drained on the next edge.
    drive(1'b0, 1'b1, 2'd2, 8'hA5, 3'b111); tick();
    check("t1.QV", 32'(qv_a), 32'h2);
    check("t1.Q2", 32'(q_a[15:8]), 32'hA5);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 3'b111); tick();
    check("t1.QV_drained", 32'(qv_a), 32'h0);
    check("t1.Q2_hold", 32'(q_a[15:8]), 32'hA5);
    check("t1.Q2_nohold", 32'(q_c[15:8]), 32'h00);

    // Stall on channel 1, then simultaneous drain and load.
    drive(1'b0, 1'b1, 2'd1, 8'h11, 3'b110); tick();
    drive(1'b0, 1'b1, 2'd1, 8'h22, 3'b110);
    #1 check("t2.IR_stall", 32'(ir_a), 32'h0);
    tick(); tick();
    check("t2.Q1_held", 32'(q_a[7:0]), 32'h11);
    check("t2.QV0_held", 32'(qv_a[0]), 32'h1);
    drive(1'b0, 1'b1, 2'd1, 8'h22, 3'b111);
    #1 check("t2.IR_open", 32'(ir_a), 32'h1);
    tick();
    check("t2.Q1_new", 32'(q_a[7:0]), 32'h22);
    check("t2.QV0_kept", 32'(qv_a[0]), 32'h1);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 3'b111); tick();

    // Drops and channel 3 (a drop in the 2-channel build).
    drive(1'b1, 1'b0, 2'd0, 8'h00, 3'b111); tick();
    for (int n = 0; n < 5; n++) begin
      drive(1'b0, 1'b1, 2'd0, 8'(n), 3'b111); tick();
    end
    drive(1'b0, 1'b1, 2'd3, 8'h31, 3'b111); tick();
    check("t3.Q3_first", 32'(q_a[23:16]), 32'h31);
    drive(1'b0, 1'b1, 2'd3, 8'h32, 3'b111); tick();
    check("t3.Q3_second", 32'(q_a[23:16]), 32'h32);
    check("t3.DROPS_3ch", 32'(drops_a), 32'd5);
    check("t3.DROPS_2ch", 32'(drops_b), 32'd7);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 3'b111); tick();

    // HOLD = 0 visibility.
    drive(1'b0, 1'b1, 2'd1, 8'h3C, 3'b000); tick();
    drive(1'b0, 1'b0, 2'd0, 8'h00, 3'b000); tick();
    check("t5.Q1_valid", 32'(q_c[7:0]), 32'h3C);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 3'b001); tick();
    check("t5.Q1_zeroed", 32'(q_c[7:0]), 32'h00);
    check("t5.Q1_hold", 32'(q_a[7:0]), 32'h3C);

    // Reset overrides an accepted transfer.
    drive(1'b0, 1'b1, 2'd2, 8'h77, 3'b000); tick();
    drive(1'b1, 1'b1, 2'd2, 8'h88, 3'b111); tick();
    check("t6.QV", 32'(qv_a), 32'h0);
    check("t6.Q", 32'(q_a), 32'h0);
    check("t6.DROPS", 32'(drops_a), 32'h0);

    // Drop counter saturation.
    for (int n = 0; n < 300; n++) begin
      drive(1'b0, 1'b1, 2'd0, 8'(n), 3'b111); tick();
      if (n == 254) check("t4.DROPS_255", 32'(drops_a), 32'd255);
    end
    check("t4.DROPS_sat", 32'(drops_a), 32'd255);

    // Randomized traffic, with X on S while IV is low.
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(49) == 0);
      iv  = ($urandom_range(3) != 0);
      i_w = 8'($urandom);
      qr  = 3'($urandom);
      if (!iv && $urandom_range(3) == 0) s = 'x;
      else s = 2'($urandom_range(3));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
